fifo_burst_reader: RTL and testbench

FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

---
 rtl/fifo_burst_reader_pkg.sv | 14 +
 rtl/fifo_burst_reader_skid.sv | 72 +++++++
 rtl/fifo_burst_reader.sv | 165 ++++++++++++++++
 tb/tb_fifo_burst_reader.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_burst_reader_pkg.sv
// Shared definitions for the FIFO burst reader.
//   state_t           : controller state encoding (IDLE / WAIT / BURST)
//   BURST_COUNT_WIDTH : width of the completed-burst counter output
package fifo_burst_reader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_BURST = 2'd2
   } state_t;

   localparam int BURST_COUNT_WIDTH = 16;

endpackage

// File: rtl/fifo_burst_reader_skid.sv
// Two-entry in-order output buffer (data + last tag) for the burst reader.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   push, push_data,   : write a word and its last tag (caller never pushes
//   push_last            into a full buffer)
//   pop                : remove the oldest entry (caller only pops when count!=0)
//   head_data,         : oldest entry, valid while count!=0
//   head_last
//   count              : number of occupied entries (0..2)
module fifo_burst_reader_skid #(
   parameter int DATA_SIZE = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 push,
   input  logic [DATA_SIZE-1:0] push_data,
   input  logic                 push_last,
   input  logic                 pop,
   output logic [DATA_SIZE-1:0] head_data,
   output logic                 head_last,
   output logic [1:0]           count
);

   logic [DATA_SIZE-1:0] data0, data1;
   logic                 last0, last1;

   assign head_data = data0;
   assign head_last = last0;

   // Entry 0 is always the oldest word; entry 1 only holds a word when count==2.
   always_ff @(posedge clk) begin
      if (reset) begin
         data0 <= '0;
         data1 <= '0;
         last0 <= 1'b0;
         last1 <= 1'b0;
         count <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) begin
                  data0 <= push_data;
                  last0 <= push_last;
               end else begin
                  data1 <= push_data;
                  last1 <= push_last;
               end
               count <= count + 2'd1;
            end
            2'b01: begin
               data0 <= data1;
               last0 <= last1;
               count <= count - 2'd1;
            end
            2'b11: begin
               // Simultaneous push and pop: occupancy is unchanged, new word goes behind.
               if (count == 2'd1) begin
                  data0 <= push_data;
                  last0 <= push_last;
               end else begin
                  data0 <= data1;
                  last0 <= last1;
                  data1 <= push_data;
                  last1 <= push_last;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/fifo_burst_reader.sv
// Burst reader: pops words from a first-word-fall-through FIFO in bursts of up
// to BURST_LEN words and streams them downstream through a 2-entry buffer,
// tagging the final word of each burst.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   fifo_empty,        : upstream FIFO status and head word
//   fifo_data,
//   fifo_size
//   fifo_read          : pop strobe to the upstream FIFO
//   out_data, out_last,: downstream word, last-of-burst tag, valid
//   out_valid
//   out_ready          : downstream accept
//   busy               : controller active or words still buffered
//   burst_count        : completed bursts (wraps)
// Optional feature: define FIFO_BURST_READER_TIMEOUT_EN to wait for a full
// burst (or TIMEOUT idle cycles) before reading.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no burst in progress, waiting for the FIFO to go non-empty
// ST_WAIT  | (timeout build only) collecting words until full or timeout
// ST_BURST | popping words while remaining!=0
module fifo_burst_reader
   import fifo_burst_reader_pkg::*;
#(
   parameter int DATA_SIZE  = 32,
   parameter int SIZE_WIDTH = 3,
   parameter int BURST_LEN  = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         fifo_empty,
   input  logic [DATA_SIZE-1:0]         fifo_data,
   input  logic [SIZE_WIDTH-1:0]        fifo_size,
   output logic                         fifo_read,
   output logic [DATA_SIZE-1:0]         out_data,
   output logic                         out_last,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         busy,
   output logic [BURST_COUNT_WIDTH-1:0] burst_count
);

   localparam logic [SIZE_WIDTH-1:0] BURST_LEN_W = SIZE_WIDTH'(BURST_LEN);

   if (BURST_LEN < 1 || BURST_LEN > (2**SIZE_WIDTH) - 1 || TIMEOUT < 1) begin : g_param_check
      $error("fifo_burst_reader: BURST_LEN or TIMEOUT out of range");
   end

   state_t                        state, state_next;
   logic [SIZE_WIDTH-1:0]         remaining, remaining_next;
   logic [BURST_COUNT_WIDTH-1:0]  burst_cnt;
   logic [1:0]                    buf_count;
   logic                          rd;
   logic                          buf_pop;

`ifdef FIFO_BURST_READER_TIMEOUT_EN
   localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [TMO_W-1:0] tmo_cnt, tmo_next;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         remaining <= '0;
         burst_cnt <= '0;
`ifdef FIFO_BURST_READER_TIMEOUT_EN
         tmo_cnt   <= '0;
`endif
      end else begin
         state     <= state_next;
         remaining <= remaining_next;
`ifdef FIFO_BURST_READER_TIMEOUT_EN
         tmo_cnt   <= tmo_next;
`endif
         if (buf_pop && out_last) begin
            burst_cnt <= burst_cnt + BURST_COUNT_WIDTH'(1);
         end
      end
   end

   always_comb begin
      state_next     = state;
      remaining_next = remaining;
      rd             = 1'b0;
`ifdef FIFO_BURST_READER_TIMEOUT_EN
      tmo_next       = tmo_cnt;
`endif
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
`ifdef FIFO_BURST_READER_TIMEOUT_EN
               state_next = ST_WAIT;
               tmo_next   = TMO_W'(TIMEOUT - 1);
`else
               state_next = ST_BURST;
               // A zero occupancy with a non-empty flag still carries one word.
               if (fifo_size == '0) begin
                  remaining_next = SIZE_WIDTH'(1);
               end else if (fifo_size > BURST_LEN_W) begin
                  remaining_next = BURST_LEN_W;
               end else begin
                  remaining_next = fifo_size;
               end
`endif
            end
         end
         ST_WAIT: begin
`ifdef FIFO_BURST_READER_TIMEOUT_EN
            if (fifo_size >= BURST_LEN_W) begin
               state_next     = ST_BURST;
               remaining_next = BURST_LEN_W;
            end else if (tmo_cnt == '0) begin
               // Flush whatever is there; if the FIFO drained meanwhile, start over.
               if (fifo_size != '0) begin
                  state_next     = ST_BURST;
                  remaining_next = fifo_size;
               end else begin
                  state_next     = ST_IDLE;
               end
            end else begin
               tmo_next = tmo_cnt - TMO_W'(1);
            end
`else
            state_next = ST_IDLE;
`endif
         end
         ST_BURST: begin
            if (remaining == '0) begin
               state_next = ST_IDLE;
            end else if (!fifo_empty && buf_count != 2'd2 && !reset) begin
               rd             = 1'b1;
               remaining_next = remaining - SIZE_WIDTH'(1);
               if (remaining == SIZE_WIDTH'(1)) begin
                  state_next = ST_IDLE;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign buf_pop = out_valid & out_ready;

   fifo_burst_reader_skid #(
      .DATA_SIZE(DATA_SIZE)
   ) u_skid (
      .clk       (clk),
      .reset     (reset),
      .push      (rd),
      .push_data (fifo_data),
      .push_last (remaining == SIZE_WIDTH'(1)),
      .pop       (buf_pop),
      .head_data (out_data),
      .head_last (out_last),
      .count     (buf_count)
   );

   assign fifo_read   = rd;
   assign out_valid   = (buf_count != 2'd0);
   assign busy        = (state != ST_IDLE) || (buf_count != 2'd0);
   assign burst_count = burst_cnt;

endmodule

// File: tb/tb_fifo_burst_reader.sv
module tb_fifo_burst_reader;

   localparam int DW       = 32;
   localparam int SW       = 3;
   localparam int BL       = 4;
   localparam int TMO      = 16;
   localparam int SIZE_MAX = (1 << SW) - 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          fifo_empty = 1'b1;
   logic [DW-1:0] fifo_data = '0;
   logic [SW-1:0] fifo_size = '0;
   logic          fifo_read;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          busy;
   logic [15:0]   burst_count;

   fifo_burst_reader #(
      .DATA_SIZE(DW), .SIZE_WIDTH(SW), .BURST_LEN(BL), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
      .fifo_size(fifo_size), .fifo_read(fifo_read), .out_data(out_data),
      .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .burst_count(burst_count)
   );

   always #5 clk = ~clk;

   // upstream FIFO contents and stimulus controls
   logic [DW-1:0] fifo_q[$];
   bit            hold = 1'b0;
   bit            size_zero = 1'b0;
   bit            stream_chk = 1'b0;
   int            ready_mode = 1;   // 0: ready=1, 1: ready=0, 2: random
   bit            pop_pending = 1'b0;

   // reference model and scoreboard
   logic [DW:0]   exp_q[$];         // {last, data}
   int            last_pos[$];
   bit            in_burst = 1'b0;
   bit            waiting = 1'b0;
   int            left = 0;
`ifdef FIFO_BURST_READER_TIMEOUT_EN
   int            wcnt = 0;
`endif
   int            bc_model = 0;
   int            acc_n = 0;
   int            pop_n = 0;
   bit            stall_prev = 1'b0;
   logic [DW-1:0] held_data = '0;
   logic          held_last = 1'b0;

   int            n_checks = 0;
   int            n_errors = 0;

   task automatic chk(input bit ok, input string name, input longint act, input longint req);
      n_checks++;
      if (!ok) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic void drive_fifo();
      int sz;
      sz = (fifo_q.size() > SIZE_MAX) ? SIZE_MAX : fifo_q.size();
      fifo_empty = hold || (fifo_q.size() == 0);
      fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
      fifo_size  = (size_zero || hold) ? '0 : SW'(sz);
   endfunction

   function automatic int last_mask(input int base);
      int m = 0;
      foreach (last_pos[i]) begin
         if (last_pos[i] > base && last_pos[i] - base < 31) m |= (1 << (last_pos[i] - base));
      end
      return m;
   endfunction

   // upstream FIFO and downstream ready driver
   always @(posedge clk) begin
      #1;
      if (pop_pending && fifo_q.size() != 0) void'(fifo_q.pop_front());
      case (ready_mode)
         0: out_ready = 1'b1;
         1: out_ready = 1'b0;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
      drive_fifo();
   end

   // monitor: burst-rule model on the read side, scoreboard on the output side
   always @(negedge clk) begin
      logic [DW:0] e;
      int sz;
      if (reset) begin
         chk(fifo_read == 1'b0, "read_in_reset", fifo_read, 0);
         exp_q.delete();
         in_burst    = 1'b0;
         waiting     = 1'b0;
         left        = 0;
         bc_model    = 0;
         stall_prev  = 1'b0;
         pop_pending = 1'b0;
      end else begin
         chk(out_valid == (exp_q.size() != 0), "out_valid", out_valid, exp_q.size() != 0);
         chk(burst_count == 16'(bc_model), "burst_count", burst_count, bc_model);
         chk(busy == (in_burst || waiting || exp_q.size() != 0), "busy", busy,
             in_burst || waiting || exp_q.size() != 0);
         if (stall_prev) begin
            chk(out_valid && out_data == held_data && out_last == held_last, "stall_stable",
                out_data, held_data);
         end
         if (out_valid && out_ready) begin
            chk(exp_q.size() != 0, "unexpected_out", out_data, 0);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk(out_data == e[DW-1:0], "out_data", out_data, e[DW-1:0]);
               chk(out_last == e[DW], "out_last", out_last, e[DW]);
               acc_n++;
               if (e[DW]) begin
                  bc_model++;
                  last_pos.push_back(acc_n);
               end
            end
         end
         stall_prev = out_valid && !out_ready;
         held_data  = out_data;
         held_last  = out_last;

         if (stream_chk && in_burst && !fifo_empty) begin
            chk(fifo_read == 1'b1, "stream_bubble", fifo_read, 1);
         end
         pop_pending = fifo_read;
         if (fifo_read) begin
            pop_n++;
            chk(!fifo_empty && in_burst, "unexpected_read", fifo_empty, 0);
            if (in_burst && !fifo_empty) begin
               exp_q.push_back({(left == 1), fifo_data});
               left--;
               if (left == 0) in_burst = 1'b0;
            end
         end else if (!in_burst) begin
            sz = int'(fifo_size);
`ifdef FIFO_BURST_READER_TIMEOUT_EN
            if (waiting) begin
               if (sz >= BL) begin
                  in_burst = 1'b1; left = BL; waiting = 1'b0;
               end else if (wcnt == TMO - 1) begin
                  waiting = 1'b0;
                  if (sz != 0) begin in_burst = 1'b1; left = sz; end
               end else begin
                  wcnt++;
               end
            end else if (!fifo_empty) begin
               waiting = 1'b1; wcnt = 0;
            end
`else
            if (!fifo_empty) begin
               in_burst = 1'b1;
               left = (sz == 0) ? 1 : ((sz > BL) ? BL : sz);
            end
`endif
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic push_words(input int n);
      for (int i = 0; i < n; i++) fifo_q.push_back($urandom);
      drive_fifo();
   endtask

   task automatic wait_idle(input string name);
      int t = 0;
      while ((fifo_q.size() != 0 || busy || exp_q.size() != 0) && t < 500) begin
         tick(1);
         t++;
      end
      chk(t < 500, {name, "_drain_timeout"}, t, 500);
   endtask

   task automatic wait_pops(input int base, input int n, input string name);
      int t = 0;
      while (pop_n - base < n && t < 100) begin
         tick(1);
         t++;
      end
      chk(pop_n - base >= n, name, pop_n - base, n);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int base, base_p, pushed;
      drive_fifo();
      tick(3);
      chk(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
      chk(out_data == '0, "rst_out_data", out_data, 0);
      chk(out_last == 1'b0, "rst_out_last", out_last, 0);
      chk(busy == 1'b0, "rst_busy", busy, 0);
      chk(fifo_read == 1'b0, "rst_fifo_read", fifo_read, 0);
      chk(burst_count == 16'd0, "rst_burst_count", burst_count, 0);
      reset = 1'b0;
      tick(2);
      chk(out_valid == 1'b0 && busy == 1'b0 && fifo_read == 1'b0, "post_rst_idle", busy, 0);

      // six words, ready high: bursts of 4 then 2
      ready_mode = 0; tick(1);
      base = acc_n;
      push_words(6);
      wait_idle("six_words");
      chk(last_mask(base) == ((1 << 4) | (1 << 6)), "six_words_last_pos", last_mask(base), (1 << 4) | (1 << 6));
      chk(acc_n - base == 6, "six_words_count", acc_n - base, 6);
      chk(burst_count == 16'd2, "six_words_bursts", burst_count, 2);

      // downstream stalled: only two pops, then no loss
      ready_mode = 1; tick(1);
      base = acc_n; base_p = pop_n;
      push_words(4);
      tick(12);
      chk(pop_n - base_p == 2, "stall_pops", pop_n - base_p, 2);
      ready_mode = 0;
      wait_idle("stall");
      chk(acc_n - base == 4, "stall_no_loss", acc_n - base, 4);
      chk(last_mask(base) == (1 << 4), "stall_last_pos", last_mask(base), 1 << 4);
      chk(burst_count == 16'd3, "stall_bursts", burst_count, 3);

      // FIFO runs dry after 2 words, refills 5 cycles later
      base = acc_n; base_p = pop_n;
      push_words(4);
      wait_pops(base_p, 2, "gap_first_pops");
      hold = 1'b1; drive_fifo();
      tick(5);
      chk(pop_n - base_p == 2, "gap_no_pop", pop_n - base_p, 2);
      hold = 1'b0; drive_fifo();
      wait_idle("gap");
      chk(last_mask(base) == (1 << 4), "gap_last_pos", last_mask(base), 1 << 4);
      chk(acc_n - base == 4, "gap_count", acc_n - base, 4);

      // reset mid-burst with one and with two buffered words
      for (int k = 1; k <= 2; k++) begin
         ready_mode = 1; tick(1);
         base_p = pop_n;
         push_words(4);
         wait_pops(base_p, k, "rst_mid_pops");
         reset = 1'b1;
         @(negedge clk);
         chk(fifo_read == 1'b0, "rst_mid_no_read", fifo_read, 0);
         @(posedge clk); #2;
         reset = 1'b0;
         @(negedge clk);
         chk(out_valid == 1'b0, "rst_mid_out_valid", out_valid, 0);
         chk(burst_count == 16'd0, "rst_mid_burst_count", burst_count, 0);
         ready_mode = 0;
         wait_idle("rst_mid");
         chk(burst_count == 16'd1, "rst_mid_rest_burst", burst_count, 1);
      end

      // continuous stream, ready high
      ready_mode = 0; tick(1);
      base = acc_n;
      stream_chk = 1'b1;
      for (int i = 0; i < 40; i++) begin
         push_words(1);
         tick(1);
      end
      stream_chk = 1'b0;
      wait_idle("stream");
      chk(acc_n - base == 40, "stream_count", acc_n - base, 40);

`ifndef FIFO_BURST_READER_TIMEOUT_EN
      // occupancy reported as zero: single-word bursts
      base = acc_n;
      size_zero = 1'b1;
      push_words(3);
      wait_idle("size_zero");
      size_zero = 1'b0; drive_fifo();
      chk(last_mask(base) == ((1 << 1) | (1 << 2) | (1 << 3)), "size_zero_last_pos",
          last_mask(base), (1 << 1) | (1 << 2) | (1 << 3));
`else
      // partial burst flushed after the timeout
      base = acc_n; base_p = pop_n;
      push_words(2);
      tick(TMO);
      chk(pop_n - base_p == 0, "timeout_no_read", pop_n - base_p, 0);
      wait_idle("timeout");
      chk(last_mask(base) == (1 << 2), "timeout_last_pos", last_mask(base), 1 << 2);
`endif

      // random traffic and random backpressure
      ready_mode = 2;
      base = acc_n; pushed = 0;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            int n = $urandom_range(1, 3);
            push_words(n);
            pushed += n;
         end
         tick(1);
      end
      ready_mode = 0;
      wait_idle("random");
      chk(acc_n - base == pushed, "random_count", acc_n - base, pushed);

      tick(2);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
